// File: rtl/parameters.sv
// Shared sizing for the rename free list and its users.
package parameters;

    localparam int unsigned DISPATCH_WIDTH       = 2;
    localparam int unsigned PHYS_REGS            = 64;
    localparam int unsigned ARCH_REGS            = 32;
    localparam int unsigned FREELIST_DEPTH       = PHYS_REGS - ARCH_REGS;
    localparam int unsigned PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);

    // Internal widths derived from the above
    localparam int unsigned PTR_WIDTH      = $clog2(FREELIST_DEPTH);
    localparam int unsigned COUNT_WIDTH    = $clog2(FREELIST_DEPTH + 1);
    localparam int unsigned LANE_CNT_WIDTH = $clog2(DISPATCH_WIDTH + 1);

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_tag_t;
    typedef logic [LANE_CNT_WIDTH-1:0]       lane_cnt_t;

endpackage

// File: rtl/freelistIf.sv
// Push (commit side) / pop (rename side) bundle of the free list.
interface freelistIf;
    import parameters::*;

    phys_tag_t [DISPATCH_WIDTH-1:0] push_reg;
    logic      [DISPATCH_WIDTH-1:0] push_en;
    logic      [DISPATCH_WIDTH-1:0] pop_en;
    phys_tag_t [DISPATCH_WIDTH-1:0] pop_reg;
    logic                           full;
    logic                           empty;

    modport freelist (
        input  push_reg, push_en, pop_en,
        output pop_reg, full, empty
    );

    modport master (
        output push_reg, push_en, pop_en,
        input  pop_reg, full, empty
    );

endinterface

// File: rtl/freelist_compactor.sv
// Prefix count of push lanes: each enabled lane gets the number of enabled lanes
// below it as its write offset from tail, so sparse pushes pack contiguously.
module freelist_compactor
    import parameters::*;
(
    input  logic      [DISPATCH_WIDTH-1:0] push_en_i,
    output lane_cnt_t [DISPATCH_WIDTH-1:0] offset_o,
    output lane_cnt_t                      total_o
);

    lane_cnt_t acc;

    // Running prefix sum over lanes in order
    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            offset_o[i] = acc;
            acc         = acc + lane_cnt_t'(push_en_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/freelist.sv
// Circular free list of physical register tags. Pops are read combinationally
// from head; pushes are compacted and written at tail. A blocked side (pop
// while empty, push while full) is dropped as a whole without affecting the
// other side.
module freelist
    import parameters::*;
#(
    // Flag pops while empty / pushes while full (both are otherwise dropped safely)
    parameter bit CheckBlocked = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    freelistIf.freelist  fl
);

    phys_tag_t                  mem_q [FREELIST_DEPTH];
    logic [PTR_WIDTH-1:0]       head_q;
    logic [PTR_WIDTH-1:0]       tail_q;
    logic [COUNT_WIDTH-1:0]     count_q;

    lane_cnt_t [DISPATCH_WIDTH-1:0] push_offset;
    lane_cnt_t                      n_push;
    lane_cnt_t                      n_pop;
    lane_cnt_t                      push_cnt;
    lane_cnt_t                      pop_cnt;
    logic                           empty;
    logic                           full;
    logic                           wr_en   [FREELIST_DEPTH];
    phys_tag_t                      wr_data [FREELIST_DEPTH];
    logic [PTR_WIDTH-1:0]           wr_idx;

    freelist_compactor u_compactor (
        .push_en_i (fl.push_en),
        .offset_o  (push_offset),
        .total_o   (n_push)
    );

    // Status flags and free-tag offers straight from registered state
    always_comb begin
        empty = count_q < COUNT_WIDTH'(DISPATCH_WIDTH);
        full  = count_q > COUNT_WIDTH'(FREELIST_DEPTH - DISPATCH_WIDTH);
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            fl.pop_reg[i] = mem_q[head_q + PTR_WIDTH'(i)];
        end
    end

    assign fl.empty = empty;
    assign fl.full  = full;

    // Accepted pop/push counts; blocked sides contribute nothing
    always_comb begin
        n_pop = '0;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            n_pop = n_pop + lane_cnt_t'(fl.pop_en[i]);
        end
        pop_cnt  = empty ? '0 : n_pop;
        push_cnt = full  ? '0 : n_push;
    end

    // Per-entry write enables from compacted push lanes
    always_comb begin
        wr_idx = '0;
        for (int unsigned k = 0; k < FREELIST_DEPTH; k++) begin
            wr_en[k]   = 1'b0;
            wr_data[k] = '0;
        end
        if (!full) begin
            for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
                if (fl.push_en[i]) begin
                    wr_idx          = tail_q + PTR_WIDTH'(push_offset[i]);
                    wr_en[wr_idx]   = 1'b1;
                    wr_data[wr_idx] = fl.push_reg[i];
                end
            end
        end
    end

    // Tag storage; reset reloads every non-architectural tag in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < FREELIST_DEPTH; k++) begin
                mem_q[k] <= phys_tag_t'(ARCH_REGS + k);
            end
        end else begin
            for (int unsigned k = 0; k < FREELIST_DEPTH; k++) begin
                if (wr_en[k]) begin
                    mem_q[k] <= wr_data[k];
                end
            end
        end
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= COUNT_WIDTH'(FREELIST_DEPTH);
        end else begin
            head_q  <= head_q + PTR_WIDTH'(pop_cnt);
            tail_q  <= tail_q + PTR_WIDTH'(push_cnt);
            count_q <= count_q + COUNT_WIDTH'(push_cnt) - COUNT_WIDTH'(pop_cnt);
        end
    end

`ifndef SYNTHESIS
    // pop_en must be a run of ones from lane 0 upward
    a_pop_contig: assert property (@(posedge clk) disable iff (!rst_n)
        (fl.pop_en & (fl.pop_en + DISPATCH_WIDTH'(1))) == '0)
        else $error("freelist: non-contiguous pop_en %b", fl.pop_en);

    a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(CheckBlocked && empty && (|fl.pop_en)))
        else $error("freelist: pop while empty");

    a_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(CheckBlocked && full && (|fl.push_en)))
        else $error("freelist: push while full");

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= COUNT_WIDTH'(FREELIST_DEPTH))
        else $error("freelist: count %0d exceeds depth", count_q);
`endif

endmodule

// File: tb/tb_freelist.sv
// Directed test of the free list: reset image, drain, wrap, sparse push,
// full/empty blocking and asynchronous reset mid-burst.
module tb_freelist;
    import parameters::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    freelistIf fl ();

    // Blocked pops/pushes are exercised on purpose here
    freelist #(
        .CheckBlocked (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] pop, input logic [1:0] push, input int r0,
                         input int r1);
        fl.pop_en      = pop;
        fl.push_en     = push;
        fl.push_reg[0] = phys_tag_t'(r0);
        fl.push_reg[1] = phys_tag_t'(r1);
    endtask

    task automatic check_pops(input string tag, input int e0, input int e1);
        check_eq({tag, " pop_reg0"}, 32'(fl.pop_reg[0]), 32'(e0));
        check_eq({tag, " pop_reg1"}, 32'(fl.pop_reg[1]), 32'(e1));
    endtask

    initial begin
        drive(2'b00, 2'b00, 0, 0);

        // Reset image while reset is held
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst empty", 32'(fl.empty), 0);
        check_eq("rst full", 32'(fl.full), 1);
        check_pops("rst", 32, 33);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post-rst count", 32'(dut.count_q), 32);
        check_pops("post-rst", 32, 33);

        // Drain: 15 double pops, then the last two, then a blocked pop
        drive(2'b11, 2'b00, 0, 0);
        repeat (15) tick();
        check_eq("drain count", 32'(dut.count_q), 2);
        check_eq("drain empty", 32'(fl.empty), 0);
        check_pops("drain", 62, 63);
        tick();
        check_eq("drained count", 32'(dut.count_q), 0);
        check_eq("drained empty", 32'(fl.empty), 1);
        check_eq("drained head", 32'(dut.head_q), 0);
        tick();
        check_eq("blocked pop count", 32'(dut.count_q), 0);
        check_eq("blocked pop head", 32'(dut.head_q), 0);

        // Push {40,41} at empty: not visible until next cycle, then consumed
        drive(2'b00, 2'b11, 40, 41);
        check_eq("push not early", 32'(fl.pop_reg[0]), 32);
        tick();
        check_eq("push count", 32'(dut.count_q), 2);
        check_pops("pushed", 40, 41);
        drive(2'b11, 2'b00, 0, 0);
        tick();
        check_eq("repop count", 32'(dut.count_q), 0);
        check_eq("repop head", 32'(dut.head_q), 2);

        // Sparse push: lane 1 only at count 4
        drive(2'b00, 2'b11, 42, 43);
        tick();
        drive(2'b00, 2'b11, 44, 45);
        tick();
        check_eq("count4", 32'(dut.count_q), 4);
        drive(2'b00, 2'b10, 99, 50);
        tick();
        check_eq("sparse count", 32'(dut.count_q), 5);
        check_eq("sparse tail", 32'(dut.tail_q), 7);
        drive(2'b11, 2'b00, 0, 0);
        tick();
        check_pops("sparse p1", 44, 45);
        tick();
        check_eq("sparse count1", 32'(dut.count_q), 1);
        check_eq("sparse fifth", 32'(fl.pop_reg[0]), 50);
        drive(2'b00, 2'b11, 46, 47);
        tick();
        check_pops("sparse p3", 50, 46);
        drive(2'b11, 2'b00, 0, 0);
        tick();
        drive(2'b00, 2'b01, 48, 99);
        tick();
        check_pops("sparse p4", 47, 48);
        drive(2'b11, 2'b00, 0, 0);
        tick();
        check_eq("sparse done count", 32'(dut.count_q), 0);
        check_eq("sparse done head", 32'(dut.head_q), 10);

        // Refill 63..32 reversed; first cycle also pops while empty (blocked)
        for (int k = 0; k < 16; k++) begin
            drive((k == 0) ? 2'b11 : 2'b00, 2'b11, 63 - 2 * k, 62 - 2 * k);
            tick();
            if (k == 0) begin
                check_eq("indep push count", 32'(dut.count_q), 2);
                check_eq("indep push head", 32'(dut.head_q), 10);
            end
        end
        check_eq("refill count", 32'(dut.count_q), 32);
        check_eq("refill full", 32'(fl.full), 1);
        check_eq("refill tail wrap", 32'(dut.tail_q), 10);

        // First drain cycle pushes while full (blocked) but pops proceed
        for (int k = 0; k < 16; k++) begin
            if (k == 0) drive(2'b11, 2'b11, 1, 2);
            else        drive(2'b11, 2'b00, 0, 0);
            check_pops($sformatf("wrap pop %0d", k), 63 - 2 * k, 62 - 2 * k);
            tick();
            if (k == 0) begin
                check_eq("indep pop count", 32'(dut.count_q), 30);
                check_eq("indep pop tail", 32'(dut.tail_q), 10);
            end
        end
        check_eq("wrap count", 32'(dut.count_q), 0);
        check_eq("wrap head", 32'(dut.head_q), 10);

        // Build count 10, simultaneous push+pop, then async reset mid-burst
        for (int k = 0; k < 5; k++) begin
            drive(2'b00, 2'b11, 2 * k + 1, 2 * k + 2);
            tick();
        end
        check_eq("burst count", 32'(dut.count_q), 10);
        drive(2'b11, 2'b11, 11, 12);
        check_pops("burst pre", 1, 2);
        tick();
        check_eq("pushpop count", 32'(dut.count_q), 10);
        check_pops("pushpop", 3, 4);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst count", 32'(dut.count_q), 32);
        check_eq("midrst head", 32'(dut.head_q), 0);
        check_eq("midrst tail", 32'(dut.tail_q), 0);
        check_eq("midrst full", 32'(fl.full), 1);
        check_eq("midrst empty", 32'(fl.empty), 0);
        check_pops("midrst", 32, 33);
        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0);
        rst_n = 1'b1;
        tick();
        check_eq("final count", 32'(dut.count_q), 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
